// File: rtl/pipeline_alu.sv
// Four-stage register-to-register ALU pipeline: operand read, ALU, register
// writeback, and memory store. The stage-3/4 result register drives zout.
module pipeline_alu #(
  parameter int unsigned DW   = 16,
  parameter int unsigned NREG = 16,
  parameter int unsigned AW   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid,
  input  logic [$clog2(NREG)-1:0]  rs1,
  input  logic [$clog2(NREG)-1:0]  rs2,
  input  logic [$clog2(NREG)-1:0]  rd,
  input  logic [3:0]               func,
  input  logic [AW-1:0]            addr,
  output logic [DW-1:0]            zout
);

  localparam int unsigned RW    = $clog2(NREG);
  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] regbank [0:NREG-1];
  logic [DW-1:0] mem     [0:DEPTH-1];

  logic          v12, v23, v34;
  logic [DW-1:0] l12_a, l12_b;
  logic [RW-1:0] l12_rd;
  logic [3:0]    l12_func;
  logic [AW-1:0] l12_addr;
  logic [DW-1:0] l23_z;
  logic [RW-1:0] l23_rd;
  logic [AW-1:0] l23_addr;
  logic [DW-1:0] l34_z;
  logic [AW-1:0] l34_addr;
  logic [DW-1:0] alu_z_c;

  // Combinational ALU over the stage-1/2 operands; unused codes yield zero.
  always_comb begin
    alu_z_c = '0;
    unique case (l12_func)
      4'd0:    alu_z_c = l12_a + l12_b;
      4'd1:    alu_z_c = l12_a - l12_b;
      4'd2:    alu_z_c = l12_a * l12_b;
      4'd3:    alu_z_c = l12_a;
      4'd4:    alu_z_c = l12_b;
      4'd5:    alu_z_c = l12_a & l12_b;
      4'd6:    alu_z_c = l12_a | l12_b;
      4'd7:    alu_z_c = l12_a ^ l12_b;
      4'd8:    alu_z_c = ~l12_a;
      4'd9:    alu_z_c = ~l12_b;
      4'd10:   alu_z_c = l12_a >> 1;
      4'd11:   alu_z_c = l12_a << 1;
      default: alu_z_c = '0;
    endcase
  end

  // Stages 1-3 and the register bank; payload registers only load behind a
  // valid bit so idle-cycle garbage never enters the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v12      <= 1'b0;
      v23      <= 1'b0;
      v34      <= 1'b0;
      l12_a    <= '0;
      l12_b    <= '0;
      l12_rd   <= '0;
      l12_func <= '0;
      l12_addr <= '0;
      l23_z    <= '0;
      l23_rd   <= '0;
      l23_addr <= '0;
      l34_z    <= '0;
      l34_addr <= '0;
      for (int unsigned i = 0; i < NREG; i++) begin
        regbank[i] <= DW'(i);
      end
    end else begin
      v12 <= valid;
      v23 <= v12;
      v34 <= v23;
      if (valid) begin
        l12_a    <= regbank[rs1];
        l12_b    <= regbank[rs2];
        l12_rd   <= rd;
        l12_func <= func;
        l12_addr <= addr;
      end
      if (v12) begin
        l23_z    <= alu_z_c;
        l23_rd   <= l12_rd;
        l23_addr <= l12_addr;
      end
      if (v23) begin
        regbank[l23_rd] <= l23_z;
        l34_z           <= l23_z;
        l34_addr        <= l23_addr;
      end
    end
  end

  // Stage 4 store; memory contents survive reset, v34 is cleared by it.
  always_ff @(posedge clk) begin
    if (v34) begin
      mem[l34_addr] <= l34_z;
    end
  end

  assign zout = l34_z;

endmodule

// File: tb/tb_pipeline_alu.sv
// Randomized and directed bench for pipeline_alu with a queue scoreboard and
// an issue-time reference model of register, result and memory timing.
module tb_pipeline_alu;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [3:0]  rs1   = '0;
  logic [3:0]  rs2   = '0;
  logic [3:0]  rd    = '0;
  logic [3:0]  func  = '0;
  logic [7:0]  addr  = '0;
  logic [15:0] zout;

  pipeline_alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (valid),
    .rs1   (rs1),
    .rs2   (rs2),
    .rd    (rd),
    .func  (func),
    .addr  (addr),
    .zout  (zout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          issue;
    logic [3:0]  rd;
    logic [7:0]  addr;
    logic [15:0] z;
  } inst_t;

  typedef struct {
    int          due;
    logic [15:0] z;
  } exp_t;

  inst_t       pend[$];
  exp_t        exp_q[$];
  logic [15:0] mreg [16];
  logic [15:0] mmem [256];
  bit          mwr  [256];
  int          cyc    = 0;
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] last_z = '0;

  // Reference ALU: plain unsigned arithmetic reduced modulo 2**16.
  function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input int f);
    int unsigned ua = 32'(a);
    int unsigned ub = 32'(b);
    int unsigned r;
    case (f)
      0:       r = ua + ub;
      1:       r = ua + 32'd65536 - ub;
      2:       r = ua * ub;
      3:       r = ua;
      4:       r = ub;
      5:       r = ua & ub;
      6:       r = ua | ub;
      7:       r = ua ^ ub;
      8:       r = 32'd65535 - ua;
      9:       r = 32'd65535 - ub;
      10:      r = ua / 2;
      11:      r = ua * 2;
      default: r = 0;
    endcase
    return 16'(r % 32'd65536);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    exp_q.delete();
    last_z = '0;
    for (int i = 0; i < 16; i++) mreg[i] = 16'(i);
  endtask

  // One clock edge; retires model writes that land on this edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    for (int i = 0; i < pend.size(); i++) begin
      if (pend[i].issue + 2 == cyc) mreg[pend[i].rd] = pend[i].z;
      if (pend[i].issue + 3 == cyc) begin
        mmem[pend[i].addr] = pend[i].z;
        mwr[pend[i].addr]  = 1'b1;
      end
    end
    while (pend.size() > 0 && pend[0].issue + 3 <= cyc) void'(pend.pop_front());
    #1;
  endtask

  task automatic issue(input int r1, input int r2, input int d, input int f, input int a);
    inst_t       it;
    exp_t        ex;
    logic [15:0] z;
    z        = ref_alu(mreg[r1], mreg[r2], f);
    it.issue = cyc + 1;
    it.rd    = 4'(d);
    it.addr  = 8'(a);
    it.z     = z;
    ex.due   = cyc + 3;
    ex.z     = z;
    pend.push_back(it);
    exp_q.push_back(ex);
    valid = 1'b1;
    rs1   = 4'(r1);
    rs2   = 4'(r2);
    rd    = 4'(d);
    func  = 4'(f);
    addr  = 8'(a);
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      valid = 1'b0;
      rs1   = 4'($urandom);
      rs2   = 4'($urandom);
      rd    = 4'($urandom);
      func  = 4'($urandom);
      addr  = 8'($urandom);
      tick();
    end
  endtask

  task automatic check_state();
    for (int i = 0; i < 16; i++) check($sformatf("regbank[%0d]", i), dut.regbank[i], mreg[i]);
    for (int a = 0; a < 256; a++) if (mwr[a]) check($sformatf("mem[%0d]", a), dut.mem[a], mmem[a]);
  endtask

  // Scoreboard monitor: pops an expected result on its due cycle, otherwise
  // zout must hold the last result (or be zero while in reset).
  always @(negedge clk) begin
    if (!rst_n) begin
      check("zout_in_reset", zout, 16'h0000);
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_t ex;
      ex     = exp_q.pop_front();
      last_z = ex.z;
      check("zout", zout, ex.z);
    end else begin
      check("zout_hold", zout, last_z);
    end
  end

  initial begin
    logic [15:0] sweep_exp [16];
    sweep_exp = '{16'd18, 16'd12, 16'd45, 16'd15, 16'd3, 16'd3, 16'd15, 16'd12,
                  16'hFFF0, 16'hFFFC, 16'd7, 16'd30, 16'd0, 16'd0, 16'd0, 16'd0};
    for (int a = 0; a < 256; a++) mwr[a] = 1'b0;
    model_reset();

    tick();
    tick();
    rst_n = 1'b1;
    idle(5);
    check_state();
    check("regbank0_idle", dut.regbank[0], 16'h0000);

    // Single multiply, then two back-to-back issues overwriting mem[125].
    issue(6, 1, 10, 2, 125);
    idle(4);
    check("rb10_mul", dut.regbank[10], 16'd6);
    check("mem125_mul", dut.mem[125], 16'd6);
    issue(9, 8, 12, 3, 126);
    issue(2, 4, 13, 4, 125);
    idle(4);
    check("rb12", dut.regbank[12], 16'd9);
    check("rb13", dut.regbank[13], 16'd4);
    check("mem126", dut.mem[126], 16'd9);
    check("mem125_over", dut.mem[125], 16'd4);

    // Full opcode sweep with A=15, B=3, then reversed subtraction.
    for (int f = 0; f < 16; f++) issue(15, 3, 14, f, 200 + f);
    issue(3, 15, 14, 1, 220);
    idle(4);
    for (int f = 0; f < 16; f++) check($sformatf("sweep_f%0d", f), dut.mem[200 + f], sweep_exp[f]);
    check("sub_wrap", dut.mem[220], 16'hFFF4);
    check_state();

    // Hazard: immediate dependent read sees old value, 3 cycles later the new one.
    issue(7, 0, 5, 3, 10);
    issue(5, 0, 6, 3, 11);
    idle(1);
    issue(5, 0, 8, 3, 12);
    idle(4);
    check("hazard_old", dut.regbank[6], 16'd5);
    check("hazard_new", dut.regbank[8], 16'd7);
    check_state();

    // Randomized traffic with gaps.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(3) != 0)
        issue(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(15)),
              int'($urandom_range(15)), int'($urandom_range(255)));
      else
        idle(1);
    end
    idle(4);
    check_state();

    // Give three addresses known contents, then squash writes to them mid-flight.
    issue(15, 0, 1, 3, 125);
    issue(14, 0, 2, 3, 126);
    issue(13, 0, 3, 3, 127);
    idle(4);
    check_state();
    issue(1, 2, 1, 0, 125);
    issue(3, 4, 2, 0, 126);
    issue(5, 6, 3, 7, 127);
    valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("zout_async_rst", zout, 16'h0000);
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    idle(5);
    check_state();
    check("exp_q_drained", 16'(exp_q.size()), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_alu.md
Name: pipeline_alu

Overview:
- Four-stage register-to-register ALU pipeline with a 16x16 register bank and a 256x16 data memory.
- Each issued instruction reads two source registers and computes a function of them.
- The result is written back to a destination register and also stored to a memory address.
- Used as a standalone datapath demonstrator; the result of stage 3 is exported on zout.

Parameters:
- DW, 16, datapath/register width in bits.
- NREG, 16, number of registers (index width 4).
- AW, 8, memory address width (depth 2**AW = 256).

Ports:
- clk  input  1  single rising-edge clock for all stages.
- rst_n  input  1  asynchronous active-low reset.
- valid  input  1  instruction issue strobe; rs1/rs2/rd/func/addr are sampled when high.
- rs1  input  4  source register A index.
- rs2  input  4  source register B index.
- rd  input  4  destination register index.
- func  input  4  ALU operation code.
- addr  input  8  memory address for the result.
- zout  output  16  result held in the stage-3/4 pipeline register (L34_Z).

Behaviour:
- Internal storage is named regbank[0:15] and mem[0:255], both DW wide, and is accessible hierarchically to the bench.
- Reset (rst_n low, asynchronous):
  - all stage valid bits cleared;
  - all pipeline registers cleared;
  - zout = 0;
  - regbank[i] = i for i = 0..15;
  - mem is not reset.
- Stage 1 (edge n, when valid=1):
  - L12_A <= regbank[rs1], L12_B <= regbank[rs2];
  - latch rd, func and addr;
  - v12 <= valid.
- Stage 2 (edge n+1): if v12, L23_Z <= ALU(L12_A, L12_B, func); forward rd and addr; v23 <= v12.
- Stage 3 (edge n+2): if v23, regbank[L23_rd] <= L23_Z and L34_Z <= L23_Z; forward addr; v34 <= v23.
- Stage 4 (edge n+3): if v34, mem[L34_addr] <= L34_Z.
- zout = L34_Z. It is valid 3 edges after issue and holds its value while no valid instruction reaches stage 3.
- Throughput is one instruction per clock. There is no stall and no backpressure.
- ALU codes (results truncated to 16 bits, unsigned, wrap-around):
  - 0 A+B; 1 A-B; 2 A*B (low 16 bits);
  - 3 A; 4 B;
  - 5 A&B; 6 A|B; 7 A^B;
  - 8 ~A; 9 ~B;
  - 10 A>>1 (logical); 11 A<<1;
  - 12-15 result 0.
- Hazards, no forwarding:
  - a source read at the same edge as a stage-3 write to the same register returns the old value;
  - a dependent instruction must issue at least 3 cycles after its producer to see the new value.
- Two in-flight instructions may target the same rd or addr; the later one wins (program order).
- Reset mid-operation squashes every in-flight instruction: no regbank or mem write occurs after rst_n falls. regbank returns to its index values.
- Inputs are ignored when valid=0, and X on those inputs must not propagate.

Test Plan:
- Reset then idle 5 cycles -> zout=0, regbank[i]=i, regbank[0]=0 unchanged (no spurious writes).
- Issue rs1=6, rs2=1, rd=10, func=2, addr=125 -> zout=6 three edges later, regbank[10]=6, mem[125]=6 one edge after that.
- Back-to-back issues:
  - rs1=9, rs2=8, rd=12, func=3, addr=126 -> regbank[12]=9, mem[126]=9;
  - next cycle rs1=2, rs2=4, rd=13, func=4, addr=125 -> regbank[13]=4, mem[125]=4 (overwrites the prior 6).
- ALU sweep with A=regbank[15]=15, B=regbank[3]=3:
  - add 18, sub 12, mul 45;
  - and 3, or 15, xor 12;
  - ~A 16'hFFF0, shr 7, shl 30;
  - func 13 -> 0;
  - sub with A=3, B=15 -> 16'hFFF4.
- Hazard check: write rd=5 with func=3 from regbank[7], then immediately read rs1=5 -> old value 5 is used. The same read 3 cycles later -> 7.
- Assert rst_n low while 3 instructions are in flight -> zout=0 immediately, and no mem or regbank updates from the squashed instructions.
